// File: rtl/framebuffer_fifo.sv
// Pixel FIFO between an upstream pixel source and DVI display timing.
// Resynchronises on start-of-frame, primes to PREFILL before streaming, and counts underruns.
module framebuffer_fifo #(
  parameter int DEPTH   = 1024,
  parameter int PREFILL = 512
) (
  input  logic                     clk_dvi,
  input  logic                     rst_n,
  input  logic [23:0]              pix_in_data,
  input  logic                     pix_in_valid,
  input  logic                     pix_in_sof,
  output logic                     pix_in_ready,
  output logic                     framebuffer_ready,
  input  logic                     framebuffer_pull,
  output logic [23:0]              framebuffer_data,
  output logic                     framebuffer_valid,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [15:0]              underrun_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);
  localparam logic [AW:0] PRE = (AW+1)'(PREFILL);

  typedef enum logic [1:0] {
    SYNC      = 2'd0,
    FILLING   = 2'd1,
    STREAMING = 2'd2,
    UNDERRUN  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [1:0]  rst_sync;
  logic        run;
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] wr_nx;
  logic [AW:0] rd_nx;
  logic        accept;
  logic        wr_en;
  logic        pop;
  logic        underrun;
  logic [23:0] mem [DEPTH];

  // Reset release synchroniser; assertion stays asynchronous.
  always_ff @(posedge clk_dvi or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run = rst_sync[1];

  // Input is held off until the synchronised reset release has completed.
  assign pix_in_ready = run && ((state != UNDERRUN) || pix_in_sof) && (fill_level < CAP);
  assign accept       = pix_in_valid & pix_in_ready;

  // Next-state, write/pop decisions and next pointer values.
  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    pop      = 1'b0;
    underrun = 1'b0;
    case (state)
      SYNC, UNDERRUN: begin
        if (accept && pix_in_sof) begin
          wr_en    = 1'b1;
          state_nx = FILLING;
        end else begin
          wr_en    = 1'b0;
        end
      end
      FILLING: begin
        wr_en = accept;
      end
      STREAMING: begin
        wr_en = accept;
        if (framebuffer_pull) begin
          if (fill_level != '0) begin
            pop = 1'b1;
          end else begin
            underrun = 1'b1;
            state_nx = UNDERRUN;
          end
        end else begin
          pop = 1'b0;
        end
      end
      default: begin
        state_nx = SYNC;
      end
    endcase
    wr_nx = wr_ptr + (AW+1)'(wr_en);
    // Underrun flushes everything, including a pixel written in the same cycle.
    rd_nx = underrun ? wr_nx : (rd_ptr + (AW+1)'(pop));
    if ((state == FILLING) && ((wr_nx - rd_nx) >= PRE)) begin
      state_nx = STREAMING;
    end else begin
      state_nx = state_nx;
    end
  end

  // Control state, pointers, occupancy and registered read port.
  always_ff @(posedge clk_dvi or negedge rst_n) begin
    if (!rst_n) begin
      state             <= SYNC;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fill_level        <= '0;
      framebuffer_ready <= 1'b0;
      framebuffer_valid <= 1'b0;
      framebuffer_data  <= 24'h000000;
      underrun_count    <= 16'h0000;
    end else begin
      state             <= state_nx;
      wr_ptr            <= wr_nx;
      rd_ptr            <= rd_nx;
      fill_level        <= wr_nx - rd_nx;
      framebuffer_ready <= (state_nx == STREAMING);
      framebuffer_valid <= pop;
      framebuffer_data  <= pop ? mem[rd_ptr[AW-1:0]] : 24'h000000;
      if (underrun && (underrun_count != 16'hFFFF)) begin
        underrun_count <= underrun_count + 16'd1;
      end
    end
  end

  // Pixel storage; contents need no reset.
  always_ff @(posedge clk_dvi) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= pix_in_data;
    end
  end

endmodule
